// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser plus delay flop for the RX pin, with falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic s1, s2, s3;

  // Flops reset to the idle line level so reset itself never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    rxd_s = s2;
    fall  = s3 & ~s2;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_done,
  output logic                 uart_parity_err,
  output logic                 uart_frame_err,
  output logic                 uart_busy
);

  localparam int unsigned BAUD_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned CW       = cnt_width(BAUD_MAX);
  localparam int unsigned SP       = BAUD_MAX / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DP       = SP + 1;
`else
  localparam int unsigned DP       = SP;
`endif

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_MAX - 1);
  localparam logic [CW-1:0] CNT_DEC   = CW'(DP);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e state, state_nx;

  logic                 rxd_s;
  logic                 start_fall;
  logic                 start_en;
  logic [CW-1:0]        baud_cnt;
  logic                 tick;
  logic                 bit_val;
  logic [3:0]           bit_cnt;
  logic                 last_data;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_exp;
  logic                 par_bad;
  logic                 frame_bad;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (uart_rxd),
    .rxd_s (rxd_s),
    .fall  (start_fall)
  );

  always_comb begin
    start_en  = start_fall && (state == S_IDLE);
    tick      = (baud_cnt == CNT_DEC);
    last_data = (bit_cnt == DATA_LAST);
    last_stop = (bit_cnt == STOP_LAST);
    par_exp   = (PARITY == PAR_EVEN) ? ^shreg : ~^shreg;
    uart_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)
      baud_cnt <= '0;
    else if (start_en || baud_cnt == CNT_LAST)
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + CW'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  logic v_early, v_mid;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_early <= 1'b1;
      v_mid   <= 1'b1;
    end else begin
      if (baud_cnt == CW'(SP - 1)) v_early <= rxd_s;
      if (baud_cnt == CW'(SP))     v_mid   <= rxd_s;
    end
  end

  // Third vote is the live sample at SP+1, where the decision is taken.
  always_comb bit_val = (v_early & v_mid) | (v_early & rxd_s) | (v_mid & rxd_s);
`else
  always_comb bit_val = rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Transitions happen at the decision point, so each state spans one bit centre to the next.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_en) state_nx = S_START;
      S_START:  if (tick) state_nx = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (tick && last_data)
                  state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nx = S_STOP;
      S_STOP:   if (tick && last_stop) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg           <= '0;
      bit_cnt         <= '0;
      par_bad         <= 1'b0;
      frame_bad       <= 1'b0;
      uart_rx_data    <= '0;
      uart_rx_done    <= 1'b0;
      uart_parity_err <= 1'b0;
      uart_frame_err  <= 1'b0;
    end else begin
      uart_rx_done <= 1'b0;
      if (tick) begin
        case (state)
          S_START: begin
            bit_cnt   <= '0;
            par_bad   <= 1'b0;
            frame_bad <= 1'b0;
          end
          S_DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          end
          S_PARITY: par_bad <= (bit_val != par_exp);
          S_STOP: begin
            if (last_stop) begin
              bit_cnt         <= '0;
              uart_rx_done    <= 1'b1;
              uart_rx_data    <= shreg;
              uart_parity_err <= par_bad;
              uart_frame_err  <= frame_bad | ~bit_val;
            end else begin
              bit_cnt   <= bit_cnt + 4'd1;
              frame_bad <= frame_bad | ~bit_val;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: four configurations (8N1, 8E1, 7O2, 9N1) at 16 clocks/bit.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 100000;
  localparam int BIT_CYC  = 16;
  // 8N1: (1+8+0+1-1)*16 + 7 + 2 = 153 from synchronised edge, +2 sync stages from pin.
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_8N1 = 156;
`else
  localparam int LAT_8N1 = 155;
`endif

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         exp_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rxd = '1;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic [3:0] done, perr, ferr, busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .uart_rx_data(d0), .uart_rx_done(done[0]),
    .uart_parity_err(perr[0]), .uart_frame_err(ferr[0]), .uart_busy(busy[0]));
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .uart_rx_data(d1), .uart_rx_done(done[1]),
    .uart_parity_err(perr[1]), .uart_frame_err(ferr[1]), .uart_busy(busy[1]));
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .uart_rx_data(d2), .uart_rx_done(done[2]),
    .uart_parity_err(perr[2]), .uart_frame_err(ferr[2]), .uart_busy(busy[2]));
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[3]), .uart_rx_data(d3), .uart_rx_done(done[3]),
    .uart_parity_err(perr[3]), .uart_frame_err(ferr[3]), .uart_busy(busy[3]));

  function automatic logic [8:0] get_data(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {2'b00, d2};
      default: return d3;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input int inst, input logic [8:0] data, input logic p,
                          input logic f, input int lat);
    exp_t e;
    e.inst    = inst;
    e.data    = data;
    e.perr    = p;
    e.ferr    = f;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic mon_step();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done[i]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done_inst", i, -1);
        end else begin
          e = sbq.pop_front();
          chk("done_inst", i, e.inst);
          chk("rx_data", int'(get_data(i)), int'(e.data));
          chk("parity_err", int'(perr[i]), int'(e.perr));
          chk("frame_err", int'(ferr[i]), int'(e.ferr));
          if (e.exp_cyc >= 0) chk("done_cycle", cyc, e.exp_cyc);
        end
      end
    end
  endtask

  // Drives n bits LSB first; the line is inverted for one cycle at cycle offset glitch.
  task automatic send(input int which, input logic [15:0] bits, input int n, input int glitch);
    for (int c = 0; c < n * BIT_CYC; c++) begin
      logic v;
      v = bits[c / BIT_CYC];
      if (c == glitch) v = ~v;
      rxd[which] = v;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int which, input int ncyc);
    rxd[which] = 1'b1;
    repeat (ncyc) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", int'(d0), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_perr", int'(perr[0]), 0);
    chk("reset_ferr", int'(ferr[0]), 0);
    idle(0, 8);

    // 8N1 0xA5 with latency check
    exp_push(0, 9'h0A5, 1'b0, 1'b0, LAT_8N1);
    send(0, {1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(0, 32);

    // 8E1 0x03: wrong parity bit, then correct one
    exp_push(1, 9'h003, 1'b1, 1'b0, -1);
    send(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11, -1);
    idle(1, 32);
    exp_push(1, 9'h003, 1'b0, 1'b0, -1);
    send(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11, -1);
    idle(1, 32);

    // 8N1 0x3C with low stop bit, line then stuck low for 40 bits
    exp_push(0, 9'h03C, 1'b0, 1'b1, -1);
    send(0, {1'b0, 8'h3C, 1'b0}, 10, -1);
    repeat (40 * BIT_CYC) @(negedge clk);
    idle(0, 32);
    exp_push(0, 9'h081, 1'b0, 1'b0, -1);
    send(0, {1'b1, 8'h81, 1'b0}, 10, -1);
    idle(0, 32);

    // false start: 4-cycle low pulse
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("false_start_busy_hi", int'(busy[0]), 1);
    repeat (8) @(negedge clk);
    chk("false_start_busy_lo", int'(busy[0]), 0);
    idle(0, 32);

`ifdef UART_RX_MAJORITY_EN
    // one-cycle high glitch at the centre of data bit 3 of 0x00
    exp_push(0, 9'h000, 1'b0, 1'b0, -1);
    send(0, {1'b1, 8'h00, 1'b0}, 10, 4 * BIT_CYC + 8);
    idle(0, 32);
`endif

    // 7O2 back-to-back: 0x55 (4 ones, parity 1), 0x2A (3 ones, parity 0)
    exp_push(2, 9'h055, 1'b0, 1'b0, -1);
    exp_push(2, 9'h02A, 1'b0, 1'b0, -1);
    send(2, {2'b11, 1'b1, 7'h55, 1'b0}, 11, -1);
    send(2, {2'b11, 1'b0, 7'h2A, 1'b0}, 11, -1);
    idle(2, 32);

    // 9N1: preload 0x0AA, abort 0x1FF with reset, then 0x155
    exp_push(3, 9'h0AA, 1'b0, 1'b0, -1);
    send(3, {1'b1, 9'h0AA, 1'b0}, 11, -1);
    idle(3, 32);
    chk("pre_abort_data", int'(d3), 'h0AA);
    fork
      send(3, {1'b1, 9'h1FF, 1'b0}, 11, -1);
      begin
        repeat (3 * BIT_CYC + 5) @(negedge clk);
        chk("pre_abort_busy", int'(busy[3]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_data", int'(d3), 0);
        chk("abort_busy", int'(busy[3]), 0);
        chk("abort_perr", int'(perr[3]), 0);
        chk("abort_ferr", int'(ferr[3]), 0);
      end
    join
    idle(3, 32);
    exp_push(3, 9'h155, 1'b0, 1'b0, -1);
    send(3, {1'b1, 9'h155, 1'b0}, 11, -1);
    idle(3, 48);

    chk("scoreboard_pending", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor receiver for asynchronous serial input. Frame format is configurable: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits. Rejects false starts, flags parity and framing errors, and delivers one word per frame with a single-cycle done strobe. Sits between the board RX pin and the command/loopback logic, in place of the fixed 8N1 receiver.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS, legal range 8 or more
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
uart_rxd  in  1  asynchronous serial input; idle high
uart_rx_data  out  DATA_BITS  last received word; held until the next done
uart_rx_done  out  1  one-cycle strobe: word and flags are valid
uart_parity_err  out  1  parity mismatch for the current word; 0 when PARITY=0
uart_frame_err  out  1  a stop bit was sampled low
uart_busy  out  1  high while the state is not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 1 (idle line level).
- uart_rxd passes through a 2-flop synchroniser plus one delay flop. start_en = (prev=1 & cur=0) in IDLE only.
- Baud counter: runs 0..BAUD_CNT_MAX-1 and wraps. It is cleared on the cycle start_en is asserted. Sample point SP = BAUD_CNT_MAX/2-1.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: waits for start_en.
  - START: at SP the sampled bit must be 0, otherwise return to IDLE with no strobe and no flags (false start).
  - DATA: DATA_BITS samples, one at SP of each bit; the shift register fills LSB first.
  - PARITY: state is skipped when PARITY=0. The sampled bit is compared against XOR(data) for even, or ~XOR(data) for odd.
  - STOP: STOP_BITS samples. A low sample in any stop bit sets the frame error.
- Completion: the cycle after the final stop-bit sample:
  - uart_rx_done = 1 for exactly 1 cycle.
  - uart_rx_data, uart_parity_err and uart_frame_err are updated together and held until the next done.
  - State returns to IDLE in the same cycle, so a back-to-back start edge half a bit later is caught.
- A frame with errors still delivers its data and asserts done.
- Line stuck low after a frame error: no retrigger. A new frame needs the line to go high and then fall.
- rst during a frame aborts it. No done is produced, and outputs return to 0 on the next cycle.
- Edge timing: a falling edge during START/DATA/STOP is ignored and does not resynchronise the counter.
- Latency: start edge on the synchronised input to done = (1 + DATA_BITS + P + STOP_BITS - 1) * BAUD_CNT_MAX + SP + 2 cycles, where P = 1 if parity is enabled, else 0.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit is decided by a 2-of-3 majority vote of the synchronised input at baud counts SP-1, SP and SP+1. The decision is taken at SP+1, and every latency figure grows by 1 cycle.
- Undefined: single sample at SP. The vote logic is not synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - localparams PAR_NONE, PAR_ODD, PAR_EVEN
  - a constant function for BAUD_CNT_MAX and the counter width ($clog2)
- One natural sub-module, uart_rx_sync: 2-flop synchroniser, delay flop and falling-edge detect, reset to 1.

Test Plan:
Bench uses CLK_FREQ=1600000, UART_BPS=100000, giving 16 clocks per bit.
1. 8N1, send 0xA5 -> one done pulse, data=0xA5, parity_err=0, frame_err=0, and done arrives the documented latency after the start edge.
2. 8E1, send 0x03 with parity bit 1 (correct value is 0) -> done, data=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0.
3. 8N1, send 0x3C with the stop bit driven low, then hold the line low for 40 bits -> one done with frame_err=1. No further done until the line goes high, then 0x81 is received cleanly.
4. Idle line, drive 0 for 4 cycles, then 1 -> no done, busy returns to 0 before bit end. With UART_RX_MAJORITY_EN, a 1-cycle high glitch at SP in data bit 3 of 0x00 -> data=0x00.
5. 7O2 config, two back-to-back frames 0x55 and 0x2A with no idle gap -> two done pulses, data 0x55 then 0x2A, no errors.
6. 9N1, assert rst for 1 cycle mid-DATA of frame 0x1FF -> no done, outputs 0. Next frame 0x155 -> data=0x155.
